// File: rtl/jts16_scr_pkg.sv
// Shared types and constants for the S16B scroll-layer tilemap address generator.
package jts16_scr_pkg;

    localparam int unsigned PAGE_W = 4;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned MAP_W  = PAGE_W + ROW_W + COL_W;
    localparam int unsigned TXT_AW = 11;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned HSC_W  = 10;
    localparam int unsigned VSC_W  = 9;

    localparam logic [TXT_AW-1:0] ROW_BASE_DEF = 11'h7C0;
    localparam logic [TXT_AW-1:0] COL_BASE_DEF = 11'h780;

    typedef enum logic [2:0] {
        IDLE,
        ROW_RD,
        COL_CHK,
        COL_RD,
        MAP_REQ,
        DONE
    } scr_state_t;

    // Line-start snapshot of the scroll register block
    typedef struct packed {
        logic [15:0]      pages;
        logic [HSC_W-1:0] hpos;
        logic [VSC_W-1:0] vpos;
        logic             rowscr_en;
        logic             colscr_en;
        logic [8:0]       vrender;
    } line_regs_t;

endpackage

// File: rtl/jts16_scr_addr_if.sv
// Text RAM and tilemap RAM request/ack buses of one scroll layer.
interface jts16_scr_addr_if;
    import jts16_scr_pkg::*;

    logic [TXT_AW-1:0] txt_addr;
    logic              txt_req;
    logic              txt_ok;
    logic [15:0]       txt_dout;
    logic [MAP_W-1:0]  map_addr;
    logic              map_req;
    logic              map_ok;

    modport master (
        output txt_addr, txt_req, map_addr, map_req,
        input  txt_ok, txt_dout, map_ok
    );

    modport slave (
        input  txt_addr, txt_req, map_addr, map_req,
        output txt_ok, txt_dout, map_ok
    );
endinterface

// File: rtl/jts16_scr_map.sv
// Combinational tile position to tilemap word address; quadrant picks the page nibble.
module jts16_scr_map
    import jts16_scr_pkg::*;
(
    input  logic [CNT_W-1:0] col_cnt,
    input  logic [6:0]       hcoarse,
    input  logic [8:0]       vrender,
    input  logic [VSC_W-1:0] vscroll,
    input  logic [15:0]      pages,
    output logic [MAP_W-1:0] map_addr_c,
    output logic [2:0]       fine_y_c
);
    logic [9:0]        x;
    logic [8:0]        y;
    logic [1:0]        quad;
    logic [PAGE_W-1:0] page;

    always_comb begin
        x    = {1'b0, col_cnt, 3'b000} + {hcoarse, 3'b000};
        y    = vrender + vscroll;
        quad = {y[8], x[9]};
        case (quad)
            2'd0:    page = pages[3:0];
            2'd1:    page = pages[7:4];
            2'd2:    page = pages[11:8];
            default: page = pages[15:12];
        endcase
        map_addr_c = {page, y[7:3], x[8:3]};
        fine_y_c   = y[2:0];
    end
endmodule

// File: rtl/jts16_scr_addr.sv
// Per-layer scroll tilemap address generator: one tilemap word request per 8-pixel tile.
// Row/column scroll reads from text RAM exist only when JTS16_SCR_RAMSCR_EN is defined.
module jts16_scr_addr
    import jts16_scr_pkg::*;
#(
    parameter int unsigned       LAYER    = 0,
    parameter int unsigned       TILES    = 41,
    parameter logic [TXT_AW-1:0] ROW_BASE = ROW_BASE_DEF,
    parameter logic [TXT_AW-1:0] COL_BASE = COL_BASE_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                hs,
    input  logic [8:0]          vrender,
    input  logic [15:0]         scr_pages,
    input  logic [15:0]         scr_hpos,
    input  logic [15:0]         scr_vpos,
    input  logic                rowscr_en,
    input  logic                colscr_en,
    jts16_scr_addr_if.master    bus,
    output logic [2:0]          fine_x,
    output logic [2:0]          fine_y,
    output logic                busy,
    output logic                line_done
);
    localparam logic [CNT_W-1:0]  LAST_TILE = CNT_W'(TILES - 1);
    localparam logic [TXT_AW-1:0] LAYER_OFS = TXT_AW'(LAYER * 32);

    scr_state_t        state_q, state_d;
    logic [CNT_W-1:0]  c_q, c_d;
    logic [HSC_W-1:0]  hscroll_q, hscroll_d;
    logic [VSC_W-1:0]  vscroll_q, vscroll_d;
    line_regs_t        lat_q, lat_d, live, st_src;
    logic              hs_q, restart_q, restart_d, start, hs_rise;

    logic [MAP_W-1:0]  map_addr_q, map_addr_d, map_addr_c;
    logic              map_req_q, map_req_d;
    logic [TXT_AW-1:0] txt_addr_q, txt_addr_d;
    logic              txt_req_q, txt_req_d;
    logic [2:0]        fine_x_q, fine_x_d, fine_y_q, fine_y_d, fine_y_c;
    logic              busy_q, busy_d, line_done_q, line_done_d;
    logic              unused_bits;

    always_comb begin
        live.pages   = scr_pages;
        live.hpos    = scr_hpos[HSC_W-1:0];
        live.vpos    = scr_vpos[VSC_W-1:0];
        live.vrender = vrender;
`ifdef JTS16_SCR_RAMSCR_EN
        live.rowscr_en = rowscr_en;
        live.colscr_en = colscr_en;
`else
        live.rowscr_en = 1'b0;
        live.colscr_en = 1'b0;
`endif
    end

`ifdef JTS16_SCR_RAMSCR_EN
    assign unused_bits = ^{scr_hpos[15:10], scr_vpos[15:9], bus.txt_dout[15:10]};
`else
    assign unused_bits = ^{scr_hpos[15:10], scr_vpos[15:9], bus.txt_dout,
                           bus.txt_ok, rowscr_en, colscr_en};
`endif

    assign hs_rise = hs & ~hs_q;

    // Next state; an hs edge mid-line aborts via one IDLE restart cycle
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        hscroll_d = hscroll_q;
        vscroll_d = vscroll_q;
        lat_d     = lat_q;
        restart_d = 1'b0;
        start     = 1'b0;
        st_src    = lat_q;
        if (hs_rise) begin
            lat_d = live;
            c_d   = '0;
            if (state_q == IDLE) begin
                start  = 1'b1;
                st_src = live;
            end else begin
                state_d   = IDLE;
                restart_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: start = restart_q;
`ifdef JTS16_SCR_RAMSCR_EN
                ROW_RD: if (bus.txt_ok) begin
                    hscroll_d = bus.txt_dout[HSC_W-1:0];
                    state_d   = COL_CHK;
                end
                COL_RD: if (bus.txt_ok) begin
                    vscroll_d = bus.txt_dout[VSC_W-1:0];
                    state_d   = MAP_REQ;
                end
`endif
                COL_CHK: begin
                    if (lat_q.colscr_en && !c_q[0]) begin
                        state_d = COL_RD;
                    end else begin
                        state_d = MAP_REQ;
                        if (!lat_q.colscr_en) vscroll_d = lat_q.vpos;
                    end
                end
                MAP_REQ: if (bus.map_ok) begin
                    if (c_q == LAST_TILE) begin
                        state_d = DONE;
                    end else begin
                        c_d     = c_q + CNT_W'(1);
                        state_d = COL_CHK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (start) begin
            if (st_src.rowscr_en) begin
                state_d = ROW_RD;
            end else begin
                hscroll_d = st_src.hpos;
                state_d   = COL_CHK;
            end
        end
    end

    jts16_scr_map u_map (
        .col_cnt    (c_d),
        .hcoarse    (hscroll_d[HSC_W-1:3]),
        .vrender    (lat_d.vrender),
        .vscroll    (vscroll_d),
        .pages      (lat_d.pages),
        .map_addr_c (map_addr_c),
        .fine_y_c   (fine_y_c)
    );

    // Outputs are registered from the next-state values
    always_comb begin
        map_addr_d  = map_addr_c;
        map_req_d   = (state_d == MAP_REQ);
        fine_x_d    = hscroll_d[2:0];
        fine_y_d    = fine_y_c;
        busy_d      = (state_d != IDLE) || restart_d;
        line_done_d = (state_d == DONE);
        txt_addr_d  = '0;
        txt_req_d   = 1'b0;
`ifdef JTS16_SCR_RAMSCR_EN
        if (state_d == ROW_RD) begin
            txt_req_d  = 1'b1;
            txt_addr_d = ROW_BASE + LAYER_OFS + TXT_AW'(lat_d.vrender[8:3]);
        end else if (state_d == COL_RD) begin
            txt_req_d  = 1'b1;
            txt_addr_d = COL_BASE + LAYER_OFS + TXT_AW'(c_d[CNT_W-1:1]);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            c_q         <= '0;
            hscroll_q   <= '0;
            vscroll_q   <= '0;
            lat_q       <= '0;
            hs_q        <= 1'b0;
            restart_q   <= 1'b0;
            map_addr_q  <= '0;
            map_req_q   <= 1'b0;
            txt_addr_q  <= '0;
            txt_req_q   <= 1'b0;
            fine_x_q    <= '0;
            fine_y_q    <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            hscroll_q   <= hscroll_d;
            vscroll_q   <= vscroll_d;
            lat_q       <= lat_d;
            hs_q        <= hs;
            restart_q   <= restart_d;
            map_addr_q  <= map_addr_d;
            map_req_q   <= map_req_d;
            txt_addr_q  <= txt_addr_d;
            txt_req_q   <= txt_req_d;
            fine_x_q    <= fine_x_d;
            fine_y_q    <= fine_y_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
        end
    end

    assign bus.map_addr = map_addr_q;
    assign bus.map_req  = map_req_q;
    assign bus.txt_addr = txt_addr_q;
    assign bus.txt_req  = txt_req_q;
    assign fine_x       = fine_x_q;
    assign fine_y       = fine_y_q;
    assign busy         = busy_q;
    assign line_done    = line_done_q;
endmodule

// File: tb/tb_jts16_scr_addr.sv
// Bench for jts16_scr_addr: random-delay RAM responders and a per-line tile list model.
module tb_jts16_scr_addr;
    import jts16_scr_pkg::*;

    localparam int unsigned L  = 0;
    localparam int unsigned NT = 41;
    localparam int RB = 'h7C0;
    localparam int CB = 'h780;
`ifdef JTS16_SCR_RAMSCR_EN
    localparam bit RAMSCR = 1'b1;
`else
    localparam bit RAMSCR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, hs;
    logic [8:0]  vrender;
    logic [15:0] scr_pages, scr_hpos, scr_vpos;
    logic        rowscr_en, colscr_en;
    logic [2:0]  fine_x, fine_y;
    logic        busy, line_done;

    jts16_scr_addr_if bus();

    jts16_scr_addr #(.LAYER(L), .TILES(NT), .ROW_BASE(11'(RB)), .COL_BASE(11'(CB))) dut (
        .clk(clk), .rst(rst), .hs(hs), .vrender(vrender),
        .scr_pages(scr_pages), .scr_hpos(scr_hpos), .scr_vpos(scr_vpos),
        .rowscr_en(rowscr_en), .colscr_en(colscr_en), .bus(bus),
        .fine_x(fine_x), .fine_y(fine_y), .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:2047];
    int errors = 0, checks = 0;
    int dmax = 0, hold_at = 1000, done_cnt = 0;
    int got_map[$], got_fx[$], got_fy[$], got_txt[$];
    int exp_map[$], exp_fx[$], exp_fy[$], exp_txt[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] map_at(input int i);
        return (i < got_map.size()) ? 32'(got_map[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] fx_at(input int i);
        return (i < got_fx.size()) ? 32'(got_fx[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] fy_at(input int i);
        return (i < got_fy.size()) ? 32'(got_fy[i]) : 32'hFFFF_FFFF;
    endfunction

    // RAM slaves: ok decided at negedge so it is stable for the next posedge
    initial begin
        bus.map_ok = 1'b0; bus.txt_ok = 1'b0; bus.txt_dout = '0;
        forever begin
            @(negedge clk);
            bus.map_ok   = 1'b0;
            bus.txt_ok   = 1'b0;
            bus.txt_dout = mem[bus.txt_addr];
            if (!rst) begin
                chk("req_exclusive", 32'(bus.txt_req & bus.map_req), 0);
                if (!RAMSCR) chk("txt_req_tied", 32'(bus.txt_req), 0);
            end
            if (line_done) done_cnt++;
            if (bus.map_req && got_map.size() < hold_at && $urandom_range(dmax, 0) == 0) begin
                bus.map_ok = 1'b1;
                got_map.push_back(int'(bus.map_addr));
                got_fx.push_back(int'(fine_x));
                got_fy.push_back(int'(fine_y));
            end
            if (bus.txt_req && $urandom_range(dmax, 0) == 0) begin
                bus.txt_ok = 1'b1;
                got_txt.push_back(int'(bus.txt_addr));
            end
        end
    end

    // Expected tile list computed straight from the scroll arithmetic
    task automatic model_line(input int pg, input int hp, input int vp, input int vr,
                              input bit row, input bit col);
        int hscr, vs, x, y, q, page;
        bit r, cc;
        r  = row && RAMSCR;
        cc = col && RAMSCR;
        exp_map.delete(); exp_fx.delete(); exp_fy.delete(); exp_txt.delete();
        if (r) begin
            exp_txt.push_back(RB + L*32 + vr/8);
            hscr = int'(mem[RB + L*32 + vr/8]) % 1024;
        end else begin
            hscr = hp % 1024;
        end
        for (int c = 0; c < NT; c++) begin
            if (cc) begin
                if (c % 2 == 0) exp_txt.push_back(CB + L*32 + c/2);
                vs = int'(mem[CB + L*32 + c/2]) % 512;
            end else begin
                vs = vp % 512;
            end
            x    = (c*8 + (hscr/8)*8) % 1024;
            y    = (vr + vs) % 512;
            q    = (y/256)*2 + x/512;
            page = (pg >> (4*q)) & 15;
            exp_map.push_back(page*2048 + ((y/8) % 32)*64 + (x/8) % 64);
            exp_fx.push_back(hscr % 8);
            exp_fy.push_back(y % 8);
        end
    endtask

    task automatic clear_got();
        got_map.delete(); got_fx.delete(); got_fy.delete(); got_txt.delete();
        done_cnt = 0;
    endtask

    task automatic start_line(input int pg, input int hp, input int vp, input int vr,
                              input bit row, input bit col);
        model_line(pg, hp, vp, vr, row, col);
        @(negedge clk);
        scr_pages = 16'(pg); scr_hpos = 16'(hp); scr_vpos = 16'(vp);
        vrender = 9'(vr); rowscr_en = row; colscr_en = col;
        clear_got();
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        chk("busy_after_edge", 32'(busy), 1);
    endtask

    task automatic finish_line(input string tag);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, "_line_done_pulses"}, 32'(done_cnt), 1);
        chk({tag, "_busy_idle"}, 32'(busy), 0);
        chk({tag, "_n_tiles"}, 32'(got_map.size()), 32'(exp_map.size()));
        chk({tag, "_n_txt"}, 32'(got_txt.size()), 32'(exp_txt.size()));
        for (int i = 0; i < exp_map.size(); i++) begin
            chk($sformatf("%s_map[%0d]", tag, i), map_at(i), 32'(exp_map[i]));
            chk($sformatf("%s_fx[%0d]", tag, i), fx_at(i), 32'(exp_fx[i]));
            chk($sformatf("%s_fy[%0d]", tag, i), fy_at(i), 32'(exp_fy[i]));
        end
        for (int i = 0; i < exp_txt.size(); i++)
            chk($sformatf("%s_txt[%0d]", tag, i),
                (i < got_txt.size()) ? 32'(got_txt[i]) : 32'hFFFF_FFFF, 32'(exp_txt[i]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_map_addr"}, 32'(bus.map_addr), 0);
        chk({tag, "_map_req"}, 32'(bus.map_req), 0);
        chk({tag, "_txt_addr"}, 32'(bus.txt_addr), 0);
        chk({tag, "_txt_req"}, 32'(bus.txt_req), 0);
        chk({tag, "_fine_x"}, 32'(fine_x), 0);
        chk({tag, "_fine_y"}, 32'(fine_y), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_line_done"}, 32'(line_done), 0);
    endtask

    initial begin
        int pg, hp, vp, vr;
        bit row, col, seen;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        rst = 1'b1; hs = 1'b0; vrender = '0; scr_pages = '0; scr_hpos = '0; scr_vpos = '0;
        rowscr_en = 1'b0; colscr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_line('h3210, 0, 0, 0, 0, 0);
        finish_line("noscroll");
        chk("noscroll_tile0", map_at(0), 32'h0000);
        chk("noscroll_tile1", map_at(1), 32'h0001);
        chk("noscroll_tile40", map_at(40), 32'h0028);

        start_line('h3210, 'h200, 0, 0, 0, 0);
        finish_line("hpage");
        chk("hpage_tile0", map_at(0), 32'h0800);
        chk("hpage_fx", fx_at(0), 0);

        start_line('h3210, 0, 'h100, 8, 0, 0);
        finish_line("vpage");
        chk("vpage_tile0", map_at(0), 32'h1040);
        chk("vpage_fy", fy_at(0), 0);

        mem[RB + L*32 + 1] = 16'h000B;
        dmax = 2;
        start_line('h3210, 0, 0, 8, 1, 0);
        finish_line("rowscr");
        chk("rowscr_tile0", map_at(0), RAMSCR ? 32'h0041 : 32'h0040);
        chk("rowscr_fx", fx_at(0), RAMSCR ? 32'd3 : 32'd0);

        for (int i = 0; i < 21; i++) mem[CB + L*32 + i] = 16'(i*37 + 5);
        start_line('h7654, 'h013, 'h05A, 17, 0, 1);
        finish_line("colscr");
        chk("colscr_reads", 32'(got_txt.size()), RAMSCR ? 32'd21 : 32'd0);

        for (int k = 0; k < 6; k++) begin
            pg = int'($urandom) & 'hFFFF; hp = int'($urandom) & 'hFFFF;
            vp = int'($urandom) & 'hFFFF; vr = int'($urandom_range(511, 0));
            row = 1'($urandom_range(1, 0)); col = 1'($urandom_range(1, 0));
            dmax = int'($urandom_range(3, 0));
            for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
            start_line(pg, hp, vp, vr, row, col);
            finish_line($sformatf("rand%0d", k));
        end

        // Abort: hs edge while tile 10 is waiting for its ack
        dmax = 0; hold_at = 10;
        start_line('h1234, 'h0F0, 'h033, 40, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = bus.map_req && got_map.size() == 10;
        end
        chk("abort_reached_tile10", 32'(seen), 1);
        chk("abort_no_done_yet", 32'(done_cnt), 0);
        model_line('hCDEF, 'h1A7, 'h0C4, 200, 1, 1);
        scr_pages = 16'hCDEF; scr_hpos = 16'h01A7; scr_vpos = 16'h00C4;
        vrender = 9'd200; rowscr_en = 1'b1; colscr_en = 1'b1;
        clear_got();
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        chk("abort_map_req_drop", 32'(bus.map_req), 0);
        chk("abort_txt_req_drop", 32'(bus.txt_req), 0);
        hold_at = 1000;
        finish_line("abort_restart");

        // Synchronous reset in the middle of a line
        start_line('h4321, 'h055, 'h077, 99, 0, 1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_stays_idle", 32'(busy), 0);
        chk("midreset_no_req", 32'(bus.map_req | bus.txt_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
